mips_multicycle_ctrl: RTL and testbench

Control state machine for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction and handshakes with a wait-stated memory. It drives the datapath selects, including extendCntrl for the immediate extend unit (1 = sign-extend, 0 = zero-extend). It traps on illegal instructions and on memory timeout.

---
 rtl/mips_multicycle_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Control FSM for a multicycle MIPS datapath. Sequences fetch / decode /
//   execute / memory / writeback, handshakes with a wait-stated memory and
//   traps on illegal instructions or memory timeouts.
//
// Parameters
//   MEM_WAIT_MAX : last wait cycle (from 0) in which mem_ready_in is accepted
//   CNT_W        : wait counter width, 2**CNT_W must exceed MEM_WAIT_MAX
//
// Ports
//   clk_in, reset_n_in          clock, async active-low reset
//   opcode_in, funct_in         IR[31:26], IR[5:0] (sampled in DECODE)
//   zero_in                     ALU zero flag (beq)
//   mem_ready_in                memory completes current access this cycle
//   pcEn_out .. extendCntrl_out datapath controls (combinational from state)
//   instrDone_out               pulse in final cycle of each instruction
//   illegal_out, busErr_out     sticky trap causes
//   state_out                   current state (debug)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic [5:0] opcode_in,
    input  logic [5:0] funct_in,
    input  logic       zero_in,
    input  logic       mem_ready_in,
    output logic       pcEn_out,
    output logic       iorD_out,
    output logic       memRead_out,
    output logic       memWrite_out,
    output logic       irWrite_out,
    output logic       regDst_out,
    output logic       memToReg_out,
    output logic       regWrite_out,
    output logic       aluSrcA_out,
    output logic [1:0] aluSrcB_out,
    output logic [2:0] aluCntrl_out,
    output logic [1:0] pcSrc_out,
    output logic       extendCntrl_out,
    output logic       instrDone_out,
    output logic       illegal_out,
    output logic       busErr_out,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEXEC = 4'd7,
        S_RTWB   = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic             r_illegal;
    logic             r_buserr;

    logic             w_is_mem;
    logic             w_last_wait;
    logic             w_rt_legal;

    // States that wait on the memory handshake.
    assign w_is_mem    = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    assign w_last_wait = (r_cnt == CNT_W'(MEM_WAIT_MAX));

    always_comb begin
        w_rt_legal = 1'b0;
        case (funct_in)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_rt_legal = 1'b1;
            default:                               w_rt_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready_in)     w_next = S_DECODE;
                else if (w_last_wait) w_next = S_TRAP;
            end
            S_DECODE: begin
                // Decoded from the live IR bits; the latched copy is only
                // valid from the following cycle onward.
                case (opcode_in)
                    OP_LW, OP_SW:                      w_next = S_MEMADR;
                    OP_RTYPE:                          w_next = w_rt_legal ? S_RTEXEC : S_TRAP;
                    OP_BEQ:                            w_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IEXEC;
                    OP_J:                              w_next = S_JUMP;
                    default:                           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready_in)     w_next = S_MEMWB;
                else if (w_last_wait) w_next = S_TRAP;
            end
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR: begin
                if (mem_ready_in)     w_next = S_FETCH;
                else if (w_last_wait) w_next = S_TRAP;
            end
            S_RTEXEC: w_next = S_RTWB;
            S_RTWB:   w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter, latched IR fields, sticky trap flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_opcode  <= '0;
            r_funct   <= '0;
            r_illegal <= 1'b0;
            r_buserr  <= 1'b0;
        end else begin
            r_state <= w_next;

            // Counts only while a memory state waits on itself; any other
            // transition (including entry into a memory state) clears it,
            // so the entry cycle is always wait 0.
            if (w_is_mem && (w_next == r_state))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            if (r_state == S_DECODE) begin
                r_opcode <= opcode_in;
                r_funct  <= funct_in;
            end

            if ((r_state == S_DECODE) && (w_next == S_TRAP))
                r_illegal <= 1'b1;
            if (w_is_mem && (w_next == S_TRAP))
                r_buserr <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        pcEn_out        = 1'b0;
        iorD_out        = 1'b0;
        memRead_out     = 1'b0;
        memWrite_out    = 1'b0;
        irWrite_out     = 1'b0;
        regDst_out      = 1'b0;
        memToReg_out    = 1'b0;
        regWrite_out    = 1'b0;
        aluSrcA_out     = 1'b0;
        aluSrcB_out     = 2'b00;
        aluCntrl_out    = 3'b000;
        pcSrc_out       = 2'b00;
        extendCntrl_out = 1'b0;
        instrDone_out   = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead_out  = 1'b1;
                aluSrcB_out  = 2'b01;
                aluCntrl_out = ALU_ADD;
                irWrite_out  = mem_ready_in;
                pcEn_out     = mem_ready_in;
            end
            S_DECODE: begin
                aluSrcB_out     = 2'b11;
                aluCntrl_out    = ALU_ADD;
                extendCntrl_out = 1'b1;
            end
            S_MEMADR: begin
                aluSrcA_out     = 1'b1;
                aluSrcB_out     = 2'b10;
                aluCntrl_out    = ALU_ADD;
                extendCntrl_out = 1'b1;
            end
            S_MEMRD: begin
                memRead_out = 1'b1;
                iorD_out    = 1'b1;
            end
            S_MEMWB: begin
                memToReg_out  = 1'b1;
                regWrite_out  = 1'b1;
                instrDone_out = 1'b1;
            end
            S_MEMWR: begin
                memWrite_out  = 1'b1;
                iorD_out      = 1'b1;
                instrDone_out = mem_ready_in;
            end
            S_RTEXEC: begin
                aluSrcA_out = 1'b1;
                case (r_funct)
                    FN_SUB:  aluCntrl_out = ALU_SUB;
                    FN_AND:  aluCntrl_out = ALU_AND;
                    FN_OR:   aluCntrl_out = ALU_OR;
                    FN_SLT:  aluCntrl_out = ALU_SLT;
                    default: aluCntrl_out = ALU_ADD;
                endcase
            end
            S_RTWB: begin
                regDst_out    = 1'b1;
                regWrite_out  = 1'b1;
                instrDone_out = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA_out   = 1'b1;
                aluCntrl_out  = ALU_SUB;
                pcSrc_out     = 2'b01;
                pcEn_out      = zero_in;
                instrDone_out = 1'b1;
            end
            S_IEXEC: begin
                aluSrcA_out = 1'b1;
                aluSrcB_out = 2'b10;
                // Logical immediates are zero-extended, arithmetic ones
                // sign-extended.
                case (r_opcode)
                    OP_ANDI: begin aluCntrl_out = ALU_AND; extendCntrl_out = 1'b0; end
                    OP_ORI:  begin aluCntrl_out = ALU_OR;  extendCntrl_out = 1'b0; end
                    OP_SLTI: begin aluCntrl_out = ALU_SLT; extendCntrl_out = 1'b1; end
                    default: begin aluCntrl_out = ALU_ADD; extendCntrl_out = 1'b1; end
                endcase
            end
            S_IWB: begin
                regWrite_out  = 1'b1;
                instrDone_out = 1'b1;
            end
            S_JUMP: begin
                pcSrc_out     = 2'b10;
                pcEn_out      = 1'b1;
                instrDone_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_out = r_illegal;
    assign busErr_out  = r_buserr;
    assign state_out   = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Instruction-level reference model: each instruction is expanded into its
//   sequence of expected cycles (state + control vector) and pushed into a
//   scoreboard queue while the matching inputs are driven. A monitor pops one
//   entry per clock on the falling edge and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int MEM_WAIT_MAX = 15;

    logic       clk_in = 1'b0;
    logic       reset_n_in;
    logic [5:0] opcode_in, funct_in;
    logic       zero_in, mem_ready_in;
    logic       pcEn_out, iorD_out, memRead_out, memWrite_out, irWrite_out;
    logic       regDst_out, memToReg_out, regWrite_out, aluSrcA_out;
    logic [1:0] aluSrcB_out, pcSrc_out;
    logic [2:0] aluCntrl_out;
    logic       extendCntrl_out, instrDone_out, illegal_out, busErr_out;
    logic [3:0] state_out;

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(4)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .opcode_in(opcode_in), .funct_in(funct_in),
        .zero_in(zero_in), .mem_ready_in(mem_ready_in),
        .pcEn_out(pcEn_out), .iorD_out(iorD_out),
        .memRead_out(memRead_out), .memWrite_out(memWrite_out),
        .irWrite_out(irWrite_out), .regDst_out(regDst_out),
        .memToReg_out(memToReg_out), .regWrite_out(regWrite_out),
        .aluSrcA_out(aluSrcA_out), .aluSrcB_out(aluSrcB_out),
        .aluCntrl_out(aluCntrl_out), .pcSrc_out(pcSrc_out),
        .extendCntrl_out(extendCntrl_out), .instrDone_out(instrDone_out),
        .illegal_out(illegal_out), .busErr_out(busErr_out),
        .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0] st;
        logic pcEn, iorD, mRd, mWr, irW, regDst, m2r, regW, srcA;
        logic [1:0] srcB;
        logic [2:0] alu;
        logic [1:0] pcSrc;
        logic ext, done, ill, berr;
    } obs_t;

    obs_t       expq[$];
    int         checks = 0;
    int         errors = 0;
    logic       m_ill  = 1'b0;
    logic       m_berr = 1'b0;
    logic [5:0] cur_op = '0, cur_fn = '0;

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        obs_t e, got;
        if (expq.size() > 0) begin
            e   = expq.pop_front();
            got = {state_out, pcEn_out, iorD_out, memRead_out, memWrite_out,
                   irWrite_out, regDst_out, memToReg_out, regWrite_out,
                   aluSrcA_out, aluSrcB_out, aluCntrl_out, pcSrc_out,
                   extendCntrl_out, instrDone_out, illegal_out, busErr_out};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle_ctl t=%0t exp_state=%0d got=%h required=%h",
                         $time, e.st, 24'(got), 24'(e));
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic obs_t base(input logic [3:0] st);
        obs_t e = '0;
        e.st = st; e.ill = m_ill; e.berr = m_berr;
        return e;
    endfunction

    function automatic logic [2:0] rt_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic bit rt_ok(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                          6'b001100, 6'b001101, 6'b001010, 6'b000010};
    endfunction

    // One clock: drive inputs, record what the DUT must show this cycle.
    // IR inputs carry noise outside DECODE to prove the latched copy is used.
    task automatic step(input obs_t e, input logic rdy, input logic z, input bit use_ir);
        opcode_in    = use_ir ? cur_op : 6'($urandom);
        funct_in     = use_ir ? cur_fn : 6'($urandom);
        mem_ready_in = rdy;
        zero_in      = z;
        expq.push_back(e);
        @(posedge clk_in); #1;
    endtask

    task automatic do_reset();
        reset_n_in = 1'b0;
        m_ill = 1'b0; m_berr = 1'b0;
        step(base(4'd0), 1'($urandom), 1'($urandom), 0);
        reset_n_in = 1'b1;
        step(base(4'd0), 1'($urandom), 1'($urandom), 0);
    endtask

    task automatic trap_and_reset();
        for (int i = 0; i < 3; i++) step(base(4'd13), 1'($urandom), 1'($urandom), 0);
        do_reset();
    endtask

    // nw wait cycles before ready; nw > MEM_WAIT_MAX means ready never comes.
    task automatic mem_phase(input obs_t eb, input int nw, input bit is_fetch,
                             input bit is_wr, output bit tr);
        obs_t e;
        tr = 0;
        for (int i = 0; i < nw && i <= MEM_WAIT_MAX; i++)
            step(eb, 1'b0, 1'($urandom), 0);
        if (nw > MEM_WAIT_MAX) begin
            m_berr = 1'b1;
            tr = 1;
        end else begin
            e = eb;
            if (is_fetch) begin e.pcEn = 1'b1; e.irW = 1'b1; end
            if (is_wr) e.done = 1'b1;
            step(e, 1'b1, 1'($urandom), 0);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input logic z, input bit abort);
        obs_t e;
        bit   tr;
        e = base(4'd1); e.mRd = 1; e.srcB = 2'b01; e.alu = 3'b010;
        mem_phase(e, wf, 1, 0, tr);
        if (tr) begin trap_and_reset(); return; end

        cur_op = op; cur_fn = fn;
        e = base(4'd2); e.srcB = 2'b11; e.alu = 3'b010; e.ext = 1;
        step(e, 1'($urandom), 1'($urandom), 1);

        if (!op_ok(op) || (op == 6'b000000 && !rt_ok(fn))) begin
            m_ill = 1'b1;
            trap_and_reset();
            return;
        end

        case (op)
            6'b100011, 6'b101011: begin
                e = base(4'd3); e.srcA = 1; e.srcB = 2'b10; e.alu = 3'b010; e.ext = 1;
                step(e, 1'($urandom), 1'($urandom), 0);
                if (op == 6'b100011) begin
                    e = base(4'd4); e.mRd = 1; e.iorD = 1;
                    mem_phase(e, wm, 0, 0, tr);
                    if (tr) begin trap_and_reset(); return; end
                    e = base(4'd5); e.m2r = 1; e.regW = 1; e.done = 1;
                    step(e, 1'($urandom), 1'($urandom), 0);
                end else begin
                    e = base(4'd6); e.mWr = 1; e.iorD = 1;
                    if (abort) begin
                        step(e, 1'b0, 1'($urandom), 0);
                        do_reset();
                        return;
                    end
                    mem_phase(e, wm, 0, 1, tr);
                    if (tr) begin trap_and_reset(); return; end
                end
            end
            6'b000000: begin
                e = base(4'd7); e.srcA = 1; e.alu = rt_alu(fn);
                step(e, 1'($urandom), 1'($urandom), 0);
                e = base(4'd8); e.regDst = 1; e.regW = 1; e.done = 1;
                step(e, 1'($urandom), 1'($urandom), 0);
            end
            6'b000100: begin
                e = base(4'd9); e.srcA = 1; e.alu = 3'b110; e.pcSrc = 2'b01;
                e.pcEn = z; e.done = 1;
                step(e, 1'($urandom), z, 0);
            end
            6'b000010: begin
                e = base(4'd12); e.pcSrc = 2'b10; e.pcEn = 1; e.done = 1;
                step(e, 1'($urandom), 1'($urandom), 0);
            end
            default: begin
                e = base(4'd10); e.srcA = 1; e.srcB = 2'b10;
                case (op)
                    6'b001100: begin e.alu = 3'b000; e.ext = 0; end
                    6'b001101: begin e.alu = 3'b001; e.ext = 0; end
                    6'b001010: begin e.alu = 3'b111; e.ext = 1; end
                    default:   begin e.alu = 3'b010; e.ext = 1; end
                endcase
                step(e, 1'($urandom), 1'($urandom), 0);
                e = base(4'd11); e.regW = 1; e.done = 1;
                step(e, 1'($urandom), 1'($urandom), 0);
            end
        endcase
    endtask

    function automatic int rwait();
        return ($urandom_range(0, 9) == 0) ? MEM_WAIT_MAX : int'($urandom_range(0, 3));
    endfunction

    // ---------------- stimulus ----------------
    logic [5:0] legal_ops [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                                  6'b001100, 6'b001101, 6'b001010, 6'b000010};
    logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] op, fn;
        int k, wf, wm;
        reset_n_in = 1'b0; opcode_in = '0; funct_in = '0;
        zero_in = 1'b0; mem_ready_in = 1'b0;
        @(posedge clk_in); #1;
        step(base(4'd0), 1'b1, 1'b0, 0);       // held in reset
        do_reset();

        // directed
        run_instr(6'b100011, 6'h00, 0, 0, 0, 0);       // lw, 5 cycles
        run_instr(6'b001100, 6'h15, 0, 0, 0, 0);       // andi: zero-extend, and
        run_instr(6'b001000, 6'h2a, 0, 0, 0, 0);       // addi: sign-extend, add
        run_instr(6'b000100, 6'h00, 0, 0, 1, 0);       // beq taken
        run_instr(6'b000100, 6'h00, 0, 0, 0, 0);       // beq not taken
        run_instr(6'b000010, 6'h00, 3, 0, 0, 0);       // fetch with 3 waits, j
        run_instr(6'b101011, 6'h00, 0, MEM_WAIT_MAX, 0, 0); // sw, last accepted wait
        run_instr(6'b000000, 6'b101010, 0, 0, 0, 0);   // slt
        run_instr(6'b100011, 6'h00, 0, MEM_WAIT_MAX + 1, 0, 0); // MEMRD timeout
        run_instr(6'b111111, 6'h00, 0, 0, 0, 0);       // illegal opcode
        run_instr(6'b000000, 6'b000111, 0, 0, 0, 0);   // illegal funct
        run_instr(6'b101011, 6'h00, 0, 0, 0, 1);       // reset mid-MEMWR
        run_instr(6'b001101, 6'h00, MEM_WAIT_MAX + 1, 0, 0, 0); // FETCH timeout

        // randomized
        for (int n = 0; n < 250; n++) begin
            k  = $urandom_range(0, 99);
            op = legal_ops[$urandom_range(0, 8)];
            fn = (op == 6'b000000) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
            wf = rwait();
            wm = rwait();
            if (k < 4) begin
                do op = 6'($urandom); while (op_ok(op));
            end else if (k < 7) begin
                op = 6'b000000;
                do fn = 6'($urandom); while (rt_ok(fn));
            end else if (k < 9) begin
                wm = MEM_WAIT_MAX + 1;
            end else if (k < 10) begin
                wf = MEM_WAIT_MAX + 1;
            end
            run_instr(op, fn, wf, wm, 1'($urandom), (k >= 10 && k < 12));
        end

        @(negedge clk_in); #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
